// File: rtl/gate_vector_checker_if.sv
// Handshake and stimulus/response bundle for gate_vector_checker.
// The master side (bench or system controller) drives Start, Mode and Resp.
// The slave side (the checker) drives the stimulus and the result signals.
interface gate_vector_checker_if #(
  parameter int ERR_W = 4
);
  logic             Start;
  logic [2:0]       Mode;
  logic             Resp;
  logic             A;
  logic             B;
  logic             Busy;
  logic             Done;
  logic             Pass;
  logic [ERR_W-1:0] ErrCount;
  logic [2:0]       FirstErrIdx;

  modport master (
    output Start, Mode, Resp,
    input  A, B, Busy, Done, Pass, ErrCount, FirstErrIdx
  );

  modport slave (
    input  Start, Mode, Resp,
    output A, B, Busy, Done, Pass, ErrCount, FirstErrIdx
  );
endinterface

// File: rtl/gate_vector_checker.sv
// Self-test engine for 2-input gates: plays an 8-vector A/B sequence into the
// gate under test, samples its response after each hold window and reports
// mismatch count, first failing vector and pass/fail via a Start/Done handshake.
// Optional build macro GVC_STOP_ON_ERR_EN: when defined, the first mismatch
// ends the run early.
//
// state  | meaning
// IDLE   | waiting for Start; result outputs hold the last run
// APPLY  | driving vector idx, counting the hold window, then sampling Resp
// FINISH | one-cycle Done pulse with final Pass
module gate_vector_checker #(
  parameter int HOLD_CYCLES = 5,
  parameter int ERR_W       = 4
) (
  input logic                  Clk,
  input logic                  Rst,
  gate_vector_checker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [2:0]       idx_q, idx_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [2:0]       first_q, first_d;

  logic             expected;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;
  logic             last_vec;
  logic [1:0]       next_ab;

  // Fixed stimulus ROM, returns {A,B}.
  function automatic logic [1:0] vec_rom(input logic [2:0] i);
    case (i)
      3'd0:    return 2'b00;
      3'd1:    return 2'b01;
      3'd2:    return 2'b10;
      3'd3:    return 2'b11;
      3'd4:    return 2'b10;
      3'd5:    return 2'b00;
      3'd6:    return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  // Truth-table reference for the latched gate type.
  function automatic logic gate_ref(input logic [2:0] m, input logic a, input logic b);
    case (m)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~(a & b);
      3'd3:    return ~(a | b);
      3'd4:    return a ^ b;
      3'd5:    return ~(a ^ b);
      3'd6:    return ~a;
      default: return a;
    endcase
  endfunction

  // Response compare against the currently driven vector.
  always_comb begin
    expected = gate_ref(mode_q, a_q, b_q);
    mismatch = (bus.Resp != expected);
    err_next = err_q + ERR_W'(mismatch);
    next_ab  = vec_rom(idx_q + 3'd1);
`ifdef GVC_STOP_ON_ERR_EN
    last_vec = (idx_q == 3'd7) || mismatch;
`else
    last_vec = (idx_q == 3'd7);
`endif
  end

  // Next-state and output computation.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    first_d = first_q;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          mode_d     = bus.Mode;
          idx_d      = 3'd0;
          {a_d, b_d} = vec_rom(3'd0);
          err_d      = '0;
          first_d    = 3'd0;
          pass_d     = 1'b0;
          cnt_d      = 4'd0;
          busy_d     = 1'b1;
          state_d    = APPLY;
        end
      end
      APPLY: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(HOLD_CYCLES - 1)) begin
          err_d = err_next;
          if (mismatch && (err_q == '0)) first_d = idx_q;
          cnt_d = 4'd0;
          if (last_vec) begin
            state_d = FINISH;
            done_d  = 1'b1;
            pass_d  = (err_next == '0);
          end else begin
            idx_d      = idx_q + 3'd1;
            {a_d, b_d} = next_ab;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        a_d     = 1'b0;
        b_d     = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      mode_q  <= 3'd0;
      idx_q   <= 3'd0;
      cnt_q   <= 4'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      first_q <= 3'd0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  assign bus.A           = a_q;
  assign bus.B           = b_q;
  assign bus.Busy        = busy_q;
  assign bus.Done        = done_q;
  assign bus.Pass        = pass_q;
  assign bus.ErrCount    = err_q;
  assign bus.FirstErrIdx = first_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Self-checking bench for gate_vector_checker. The gate under test is modelled
// as a 4-entry truth table indexed by {A,B}; expected results come from a
// table-driven reference over the stimulus ROM.
module tb_gate_vector_checker;

  localparam int H     = 5;
  localparam int ERR_W = 4;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic [3:0] resp_tt = 4'b0000;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] rom [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b00, 2'b11, 2'b01};

  gate_vector_checker_if #(.ERR_W(ERR_W)) bus ();

  gate_vector_checker #(.HOLD_CYCLES(H), .ERR_W(ERR_W)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  assign bus.Resp = resp_tt[{bus.A, bus.B}];

  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Truth table of each gate type, bit index = {A,B}.
  function automatic logic [3:0] gate_tt(input logic [2:0] m);
    case (m)
      3'd0:    return 4'b1000;
      3'd1:    return 4'b1110;
      3'd2:    return 4'b0111;
      3'd3:    return 4'b0001;
      3'd4:    return 4'b0110;
      3'd5:    return 4'b1001;
      3'd6:    return 4'b0011;
      default: return 4'b1100;
    endcase
  endfunction

  task automatic check_idle_zero(input string tag);
    check_val({tag, "_a"},     int'(bus.A), 0);
    check_val({tag, "_b"},     int'(bus.B), 0);
    check_val({tag, "_busy"},  int'(bus.Busy), 0);
    check_val({tag, "_done"},  int'(bus.Done), 0);
    check_val({tag, "_pass"},  int'(bus.Pass), 0);
    check_val({tag, "_err"},   int'(bus.ErrCount), 0);
    check_val({tag, "_first"}, int'(bus.FirstErrIdx), 0);
  endtask

  task automatic run_check(input logic [2:0] mode, input logic [3:0] tt, input bit disturb);
    int n_app, errs, first, done_at;
    logic [3:0] gtt;
    bit stop;
    gtt = gate_tt(mode);
    n_app = 0; errs = 0; first = 0; stop = 0;
    for (int i = 0; i < 8; i++) begin
      if (!stop) begin
        n_app = i + 1;
        if (gtt[rom[i]] != tt[rom[i]]) begin
          if (errs == 0) first = i;
          errs++;
`ifdef GVC_STOP_ON_ERR_EN
          stop = 1;
`endif
        end
      end
    end

    @(negedge Clk);
    resp_tt   = tt;
    bus.Mode  = mode;
    bus.Start = 1'b1;
    @(posedge Clk);
    #1 bus.Start = 1'b0;

    done_at = -1;
    for (int c = 0; c < 200 && done_at < 0; c++) begin
      @(negedge Clk);
      if (disturb && c == 10) begin
        bus.Start = 1'b1;
        bus.Mode  = ~mode;
      end
      if (disturb && c == 11) bus.Start = 1'b0;
      if (bus.Done) done_at = c;
      else begin
        check_val("busy_run", int'(bus.Busy), 1);
        if (c < n_app * H) check_val("ab_seq", int'({bus.A, bus.B}), int'(rom[c / H]));
      end
    end
    check_val("done_cycle", done_at, n_app * H);
    check_val("busy_at_done", int'(bus.Busy), 1);
    check_val("pass", int'(bus.Pass), (errs == 0) ? 1 : 0);
    check_val("err_count", int'(bus.ErrCount), errs);
    check_val("first_err", int'(bus.FirstErrIdx), first);

    @(negedge Clk);
    check_val("done_pulse", int'(bus.Done), 0);
    check_val("busy_after", int'(bus.Busy), 0);
    check_val("ab_after", int'({bus.A, bus.B}), 0);
    check_val("pass_hold", int'(bus.Pass), (errs == 0) ? 1 : 0);
    check_val("err_hold", int'(bus.ErrCount), errs);
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    bus.Start = 1'b0;
    bus.Mode  = 3'd0;
    repeat (3) @(negedge Clk);
    check_idle_zero("reset");
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
    check_idle_zero("idle");

    run_check(3'd3, 4'b0001, 1'b0);   // NOR vs correct NOR
    run_check(3'd3, 4'b1000, 1'b0);   // NOR vs AND gate
    run_check(3'd4, 4'b0000, 1'b0);   // XOR vs stuck-at-0
    run_check(3'd0, 4'b1111, 1'b0);   // AND vs stuck-at-1
    run_check(3'd5, 4'b1001, 1'b1);   // XNOR correct, Start and Mode disturbed mid-run
    run_check(3'd3, 4'b1000, 1'b1);   // NOR vs AND, disturbed

    // Reset while vector 3 is being held.
    @(negedge Clk);
    resp_tt   = 4'b0000;
    bus.Mode  = 3'd4;
    bus.Start = 1'b1;
    @(posedge Clk);
    #1 bus.Start = 1'b0;
    repeat (3 * H + 2) @(negedge Clk);
    check_val("pre_rst_ab", int'({bus.A, bus.B}), int'(rom[3]));
    Rst = 1'b1;
    @(negedge Clk);
    check_idle_zero("mid_rst");
    Rst = 1'b0;
    for (int c = 0; c < 4 * H; c++) begin
      @(negedge Clk);
      if (bus.Done) check_val("no_done_after_rst", 1, 0);
    end
    check_val("idle_after_rst", int'(bus.Busy), 0);
    run_check(3'd4, 4'b0110, 1'b0);

    for (int r = 0; r < 8; r++) begin
      logic [2:0] m;
      logic [3:0] t;
      m = 3'($urandom_range(0, 7));
      t = ($urandom_range(0, 1) == 0) ? gate_tt(m) : 4'($urandom);
      run_check(m, t, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gate_vector_checker.md
Name: gate_vector_checker

Overview:
Synthesizable self-test engine for the basic 2-input gates. It plays the fixed 8-vector A/B stimulus sequence into a gate under test and samples the gate's response after each hold window. Each response is compared against the expected truth-table value for the selected gate type. The block reports mismatch count, first failing vector index, and pass/fail through a Start/Done handshake, for on-board or in-sim checking without a behavioural testbench.

Parameters:
HOLD_CYCLES, 5, clock cycles each vector is held before the response is sampled (legal 1..15)
ERR_W, 4, width of ErrCount (must hold value 8)

Ports:
Clk  input  1  single clock; all logic on rising edge
Rst  input  1  synchronous, active-high reset
Start  input  1  run request; sampled only in IDLE
Mode  input  3  gate type: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A, 7 BUF A; latched at Start
Resp  input  1  response (Out) from gate under test
A  output  1  stimulus A (registered)
B  output  1  stimulus B (registered)
Busy  output  1  high from cycle after Start accepted until Done cycle inclusive
Done  output  1  one-cycle pulse at end of run
Pass  output  1  1 if last run had zero mismatches; valid from Done until next Start
ErrCount  output  ERR_W  mismatches in last/current run
FirstErrIdx  output  3  index of first failing vector; 0 when ErrCount==0

Behaviour:
- Reset (Rst=1 at edge): state IDLE, A=0, B=0, Busy=0, Done=0, Pass=0, ErrCount=0, FirstErrIdx=0, vector index=0, hold counter=0. Reset mid-run aborts immediately; no Done is produced.
- Vector ROM, index 0..7, {A,B}: 00, 01, 10, 11, 10, 00, 11, 01.
- FSM states: IDLE, APPLY, FINISH.
- IDLE: if Start=1, then on that edge latch Mode, set idx=0, drive A/B = vector 0, clear ErrCount/FirstErrIdx/Pass, hold counter=0, Busy=1, go to APPLY. Otherwise outputs hold their values.
- APPLY: hold counter increments each cycle. When counter==HOLD_CYCLES-1:
  - compare Resp with expected(Mode, A, B);
  - on mismatch, ErrCount+1; if this is the first mismatch, FirstErrIdx=idx;
  - if idx==7, go to FINISH; else idx+1, drive the next vector, reset the counter.
- Resp is sampled after A/B have been stable for HOLD_CYCLES cycles. The gate under test is combinational, so no further latency applies.
- FINISH (one cycle): Done=1, Busy=1, Pass=(ErrCount==0) using the final count including the idx-7 compare. Next edge: IDLE, Done=0, Busy=0, A=B=0.
- Timing: with Start high at edge k, Done is high in the cycle after edge k+8*HOLD_CYCLES. Total latency is 8*HOLD_CYCLES+1 edges.
- Start while Busy is ignored. Start held high continuously restarts the run on the edge after returning to IDLE.
- Mode changes during a run are ignored; the latched value is used.
- ErrCount cannot exceed 8, so no wrap occurs at ERR_W>=4.

Optional Feature:
GVC_STOP_ON_ERR_EN
- Defined: the first mismatch ends the run. The next state is FINISH with ErrCount=1, FirstErrIdx=failing idx, Pass=0. Remaining vectors are not applied; Done arrives early.
- Undefined: all 8 vectors are always applied and every mismatch is counted.

Test Plan:
- Mode=3 (NOR), Resp wired to a correct NOR of A,B, HOLD_CYCLES=5, Start pulse -> Done 41 edges after Start; Pass=1, ErrCount=0, FirstErrIdx=0; A/B sequence matches ROM, 5 cycles each.
- Mode=3, Resp wired to an AND gate -> expected NOR 1,0,0,0,0,1,0,0 vs resp 0,0,0,1,0,0,1,0 -> ErrCount=4 (idx 0,3,5,6), FirstErrIdx=0, Pass=0.
- Mode=4 (XOR), Resp tied to 0 -> mismatches at idx 1,2,4,7 -> ErrCount=4, FirstErrIdx=1, Pass=0.
- Rst=1 asserted at vector idx 3 mid-run -> next cycle A=B=0, Busy=0, ErrCount=0, no Done pulse. A new Start then completes normally.
- Start pulsed again while Busy, and Mode toggled mid-run -> run unaffected; a single Done with results for the original Mode.
- With GVC_STOP_ON_ERR_EN defined, Mode=0 (AND), Resp tied to 1 -> mismatch at idx 0; Done 6 edges after Start; ErrCount=1, FirstErrIdx=0, Pass=0.
